// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch-stage sequencer: fetch PC, icache requests, fetch register loads
// Optional feature macro: FETCH_CTRL_PERF_EN (HOLD-cycle and redirect counters)
module fetch_controller #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = 32'h0000_1000,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  icache_req_out,
  output logic [WORD_WIDTH-1:0] icache_addr_out,
  input  logic                  icache_op_done_in,
  input  logic [WORD_WIDTH-1:0] icache_instr_in,
  input  logic                  stall_in,
  input  logic                  alu_op_done_in,
  input  logic                  redirect_in,
  input  logic [WORD_WIDTH-1:0] redirect_pc_in,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic                  valid_out,
  output logic                  set_nop_out,
  output logic [31:0]           stall_cycles_out,
  output logic [15:0]           flush_count_out
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_WIDTH-1:0] buffer_q, buffer_d;
  logic [WORD_WIDTH-1:0] instr_q, instr_d;
  logic [WORD_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                  valid_q, valid_d;
  logic                  set_nop_q, set_nop_d;

  logic                  deliver;
  logic [WORD_WIDTH-1:0] redirect_target;
  logic [WORD_WIDTH-1:0] fetch_pc_next;

  assign deliver         = ~stall_in & alu_op_done_in;
  assign redirect_target = {redirect_pc_in[WORD_WIDTH-1:2], 2'b00};
  assign fetch_pc_next   = fetch_pc_q + WORD_WIDTH'(PC_STEP);

  // Request is only live while waiting on the cache; address always tracks fetch_pc.
  assign icache_req_out  = (state_q == S_WAIT);
  assign icache_addr_out = fetch_pc_q;

  assign instruction_out = instr_q;
  assign pc_out          = pc_out_q;
  assign valid_out       = valid_q;
  assign set_nop_out     = set_nop_q;

  // Next-state decode: redirect overrides everything, otherwise deliver, buffer or drain.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    buffer_d   = buffer_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    valid_d    = 1'b0;
    set_nop_d  = 1'b0;
    if (redirect_in) begin
      fetch_pc_d = redirect_target;
      pc_out_d   = redirect_target;
      set_nop_d  = 1'b1;
      case (state_q)
        S_WAIT:  state_d = icache_op_done_in ? S_WAIT : S_DRAIN;
        S_HOLD:  state_d = S_WAIT;
        S_DRAIN: state_d = icache_op_done_in ? S_WAIT : S_DRAIN;
        default: state_d = S_WAIT;
      endcase
    end else begin
      case (state_q)
        S_WAIT: begin
          if (icache_op_done_in) begin
            if (deliver) begin
              instr_d    = icache_instr_in;
              pc_out_d   = fetch_pc_q;
              valid_d    = 1'b1;
              fetch_pc_d = fetch_pc_next;
            end else begin
              buffer_d = icache_instr_in;
              state_d  = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (deliver) begin
            instr_d    = buffer_q;
            pc_out_d   = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_next;
            state_d    = S_WAIT;
          end
        end
        S_DRAIN: begin
          if (icache_op_done_in) begin
            state_d = S_WAIT;
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_WAIT;
      fetch_pc_q <= RESET_PC;
      buffer_q   <= '0;
      instr_q    <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
      set_nop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      buffer_q   <= buffer_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      set_nop_q  <= set_nop_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: cycles spent holding a word, and redirects seen.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == S_HOLD) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (redirect_in && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_out = stall_cnt_q;
  assign flush_count_out  = flush_cnt_q;
`else
  assign stall_cycles_out = '0;
  assign flush_count_out  = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller (directed + randomized)
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_req_out;
  logic [31:0] icache_addr_out;
  logic        icache_op_done_in;
  logic [31:0] icache_instr_in;
  logic        stall_in;
  logic        alu_op_done_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        set_nop_out;
  logic [31:0] stall_cycles_out;
  logic [15:0] flush_count_out;

  fetch_controller dut (
    .clk               (clk),
    .reset             (reset),
    .icache_req_out    (icache_req_out),
    .icache_addr_out   (icache_addr_out),
    .icache_op_done_in (icache_op_done_in),
    .icache_instr_in   (icache_instr_in),
    .stall_in          (stall_in),
    .alu_op_done_in    (alu_op_done_in),
    .redirect_in       (redirect_in),
    .redirect_pc_in    (redirect_pc_in),
    .instruction_out   (instruction_out),
    .pc_out            (pc_out),
    .valid_out         (valid_out),
    .set_nop_out       (set_nop_out),
    .stall_cycles_out  (stall_cycles_out),
    .flush_count_out   (flush_count_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the fetch stage as "waiting for a word", "holding a word",
  // or "throwing away one stale word", plus the visible fetch-register outputs.
  logic [31:0] m_pc, m_word, m_instr, m_pc_out, m_stall;
  logic [15:0] m_flush;
  logic        m_have_word, m_discard, m_valid, m_nop;

  task automatic model_reset();
    m_pc = 32'h0000_1000; m_word = 0; m_instr = 0; m_pc_out = 0;
    m_stall = 0; m_flush = 0; m_have_word = 0; m_discard = 0;
    m_valid = 0; m_nop = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    m_instr  = w;
    m_pc_out = m_pc;
    m_valid  = 1'b1;
    m_pc     = m_pc + 32'd4;
  endtask

  task automatic model_step(input logic od, input logic [31:0] ins, input logic st,
                            input logic al, input logic rd, input logic [31:0] rp);
    logic go;
    go = !st && al;
    if (m_have_word && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (rd && m_flush != 16'hFFFF) m_flush = m_flush + 1;
    m_valid = 1'b0;
    m_nop   = 1'b0;
    if (rd) begin
      m_pc     = {rp[31:2], 2'b00};
      m_pc_out = m_pc;
      m_nop    = 1'b1;
      if (m_have_word) m_have_word = 1'b0;
      else             m_discard   = !od;
    end else if (m_discard) begin
      if (od) m_discard = 1'b0;
    end else if (m_have_word) begin
      if (go) begin
        m_have_word = 1'b0;
        emit(m_word);
      end
    end else if (od) begin
      if (go) emit(ins);
      else begin
        m_have_word = 1'b1;
        m_word      = ins;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_stall;
    logic [15:0] exp_flush;
`ifdef FETCH_CTRL_PERF_EN
    exp_stall = m_stall;
    exp_flush = m_flush;
`else
    exp_stall = 0;
    exp_flush = 0;
`endif
    check_eq("req", 32'(icache_req_out), 32'(!(m_have_word || m_discard)));
    check_eq("addr", icache_addr_out, m_pc);
    check_eq("valid", 32'(valid_out), 32'(m_valid));
    check_eq("set_nop", 32'(set_nop_out), 32'(m_nop));
    check_eq("instr", instruction_out, m_instr);
    check_eq("pc_out", pc_out, m_pc_out);
    check_eq("stall_cycles", stall_cycles_out, exp_stall);
    check_eq("flush_count", 32'(flush_count_out), 32'(exp_flush));
  endtask

  // Drive one cycle of inputs at the negedge, advance the model, check at the next negedge.
  task automatic cyc(input logic od, input logic [31:0] ins, input logic st,
                     input logic al, input logic rd, input logic [31:0] rp);
    icache_op_done_in = od;
    icache_instr_in   = ins;
    stall_in          = st;
    alu_op_done_in    = al;
    redirect_in       = rd;
    redirect_pc_in    = rp;
    model_step(od, ins, st, al, rd, rp);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  logic        c_busy;
  int          c_lat;
  logic [31:0] c_addr;

  initial begin
    reset = 1'b1;
    icache_op_done_in = 0; icache_instr_in = 0; stall_in = 0;
    alu_op_done_in = 1; redirect_in = 0; redirect_pc_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_nop", 32'(set_nop_out), 32'd0);
    check_eq("rst_instr", instruction_out, 32'd0);
    check_eq("rst_pc_out", pc_out, 32'd0);
    check_eq("rst_stall_cnt", stall_cycles_out, 32'd0);
    check_eq("rst_flush_cnt", 32'(flush_count_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("first_req", 32'(icache_req_out), 32'd1);
    check_eq("first_addr", icache_addr_out, 32'h0000_1000);

    // Cache answers three cycles after the request.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'h0000_0013, 0, 1, 0, 0);
    check_eq("d1_valid", 32'(valid_out), 32'd1);
    check_eq("d1_pc", pc_out, 32'h0000_1000);
    check_eq("d1_instr", instruction_out, 32'h0000_0013);
    check_eq("d1_next_addr", icache_addr_out, 32'h0000_1004);

    // Response under a 4-cycle downstream stall.
    cyc(1, 32'hCAFE_0001, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    check_eq("hold_no_req", 32'(icache_req_out), 32'd0);
    cyc(0, 0, 0, 1, 0, 0);
    check_eq("hold_valid", 32'(valid_out), 32'd1);
    check_eq("hold_instr", instruction_out, 32'hCAFE_0001);
    check_eq("hold_pc", pc_out, 32'h0000_1004);
`ifdef FETCH_CTRL_PERF_EN
    check_eq("hold_stall_cnt", stall_cycles_out, 32'd4);
`else
    check_eq("hold_stall_cnt", stall_cycles_out, 32'd0);
`endif

    // Redirect with a request outstanding: drain the stale response.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h0000_2002);
    check_eq("rd_nop", 32'(set_nop_out), 32'd1);
    check_eq("rd_drain_req", 32'(icache_req_out), 32'd0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'hDEAD_BEEF, 0, 1, 0, 0);
    check_eq("drain_no_valid", 32'(valid_out), 32'd0);
    check_eq("drain_addr", icache_addr_out, 32'h0000_2000);
`ifdef FETCH_CTRL_PERF_EN
    check_eq("drain_flush_cnt", 32'(flush_count_out), 32'd1);
`else
    check_eq("drain_flush_cnt", 32'(flush_count_out), 32'd0);
`endif

    // Redirect together with op_done: response dropped, next request at target.
    cyc(1, 32'h1111_2222, 0, 1, 1, 32'h0000_3000);
    check_eq("rdod_valid", 32'(valid_out), 32'd0);
    check_eq("rdod_nop", 32'(set_nop_out), 32'd1);
    check_eq("rdod_addr", icache_addr_out, 32'h0000_3000);
    check_eq("rdod_req", 32'(icache_req_out), 32'd1);

    // Multicycle ALU busy at op_done.
    cyc(1, 32'h0000_00AA, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check_eq("alu_valid", 32'(valid_out), 32'd1);
    check_eq("alu_pc", pc_out, 32'h0000_3000);

    // PC wrap at the top of the address space.
    cyc(1, 0, 0, 1, 1, 32'hFFFF_FFFF);
    cyc(1, 32'h0000_0BBB, 0, 1, 0, 0);
    check_eq("wrap_pc", pc_out, 32'hFFFF_FFFC);
    check_eq("wrap_addr", icache_addr_out, 32'h0000_0000);

    // Randomized traffic against a cache that accepts requests and answers after 0..3 cycles.
    c_busy = 0; c_lat = 0; c_addr = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        od;
      logic [31:0] ins;
      od  = 1'b0;
      ins = $urandom;
      if (!c_busy && icache_req_out) begin
        c_busy = 1'b1;
        c_lat  = $urandom_range(0, 3);
        c_addr = icache_addr_out;
      end
      if (c_busy) begin
        if (c_lat == 0) begin
          od     = 1'b1;
          ins    = mem_word(c_addr);
          c_busy = 1'b0;
        end else begin
          c_lat--;
        end
      end
      cyc(od, ins, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) >= 2),
          ($urandom_range(0, 19) == 0), $urandom);
      if (valid_out) check_eq("rand_word_vs_pc", instruction_out, mem_word(pc_out));
    end

    // Asynchronous reset in the middle of a cycle clears outputs immediately.
    #2 reset = 1'b1;
    #1;
    check_eq("async_valid", 32'(valid_out), 32'd0);
    check_eq("async_nop", 32'(set_nop_out), 32'd0);
    check_eq("async_instr", instruction_out, 32'd0);
    check_eq("async_pc_out", pc_out, 32'd0);
    check_eq("async_addr", icache_addr_out, 32'h0000_1000);
    check_eq("async_stall_cnt", stall_cycles_out, 32'd0);
    check_eq("async_flush_cnt", 32'(flush_count_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the fetch stage: owns the fetch PC, drives instruction-cache requests, and loads the fetch pipeline registers with the fetched word or a NOP. It sits between the instruction cache and the fetch registers. It absorbs downstream stalls by buffering one returned instruction. It resolves branch/jump redirects by flushing or draining in-flight fetches.

## Interface
- WORD_WIDTH, 32, instruction/address width
- RESET_PC, 32'h0000_1000, first fetch address after reset
- PC_STEP, 4, sequential PC increment
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- icache_req_out  out  1  fetch request to instruction cache
- icache_addr_out  out  WORD_WIDTH  fetch address, stable while icache_req_out=1
- icache_op_done_in  in  1  one-cycle pulse: icache_instr_in valid
- icache_instr_in  in  WORD_WIDTH  fetched instruction
- stall_in  in  1  downstream hazard stall
- alu_op_done_in  in  1  multicycle ALU idle; 0 blocks delivery
- redirect_in  in  1  one-cycle taken branch/jump
- redirect_pc_in  in  WORD_WIDTH  redirect target
- instruction_out  out  WORD_WIDTH  instruction to fetch registers
- pc_out  out  WORD_WIDTH  PC of instruction_out
- valid_out  out  1  one-cycle load strobe for fetch registers
- set_nop_out  out  1  one-cycle strobe: fetch registers load NOP_INSTRUCTION
- stall_cycles_out  out  32  HOLD-cycle counter (see Configuration)
- flush_count_out  out  16  redirect counter (see Configuration)

## Operation
- States: WAIT (request outstanding), HOLD (word buffered, downstream blocked), DRAIN (discarding a stale response).
- Reset values: state=WAIT, fetch_pc=RESET_PC, buffer=0, instruction_out=0, pc_out=0, valid_out=0, set_nop_out=0, counters=0. icache_req_out=1 and icache_addr_out=RESET_PC from the first cycle after reset deasserts.
- Outputs are registered. valid_out and set_nop_out are never high together.
- Request outputs are decoded from state:
  - icache_req_out=1 only in WAIT.
  - icache_addr_out=fetch_pc.
- Delivery condition: deliver = ~stall_in & alu_op_done_in.
- WAIT, icache_op_done_in=1, deliver=1:
  - instruction_out<=icache_instr_in, pc_out<=fetch_pc, valid_out<=1.
  - fetch_pc+=PC_STEP (mod 2^WORD_WIDTH; wrap allowed).
  - Stay in WAIT.
- WAIT, icache_op_done_in=1, deliver=0: buffer<=icache_instr_in, go to HOLD. fetch_pc is unchanged.
- HOLD, deliver=1: instruction_out<=buffer, pc_out<=fetch_pc, valid_out<=1, fetch_pc+=PC_STEP, go to WAIT.
- Redirect has priority over every other event. On redirect_in=1:
  - fetch_pc<=redirect_pc_in with bits[1:0] forced to 0.
  - set_nop_out<=1, pc_out<=redirect target, valid_out<=0.
  - Next state by current state and response:
    - WAIT with icache_op_done_in=0: go to DRAIN.
    - WAIT with icache_op_done_in=1: response discarded, stay in WAIT.
    - HOLD: buffer discarded, go to WAIT.
    - DRAIN: update target only.
- DRAIN: icache_req_out=0. On icache_op_done_in=1, discard the response and go to WAIT (if redirect_in=1 in the same cycle, use the new target).
- icache contract: any request the cache has accepted completes with exactly one op_done, regardless of later icache_req_out level.
- Stray icache_op_done_in in HOLD is ignored.

## Timing
- Redirect to set_nop_out: 1 cycle.
- Redirect to request at the new PC:
  - Next cycle if the response is not outstanding or arrives in the same cycle.
  - Otherwise the cycle after the drained op_done.
- op_done to valid_out: 1 cycle when deliver=1.
- HOLD release to valid_out: 1 cycle after deliver rises.
- Next request address appears the cycle after the delivering op_done. Back-to-back delivery is possible when the cache returns every cycle.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). The pending cache response is the cache's responsibility to cancel; the controller ignores op_done until back in WAIT.

## Configuration
- FETCH_CTRL_PERF_EN defined:
  - stall_cycles_out increments each cycle in HOLD.
  - flush_count_out increments on each redirect_in.
  - Both saturate at all-ones and clear on reset.
- FETCH_CTRL_PERF_EN undefined: counter logic is removed, and both ports are tied to 0 so instantiation is unchanged.

## Test plan
- Reset, cache returns 32'h0000_0013 three cycles after request -> first icache_addr_out=32'h1000; valid_out pulses with pc_out=32'h1000; next request address is 32'h1004.
- op_done with stall_in=1 held for 4 cycles -> HOLD, no request; valid_out pulses 1 cycle after stall_in drops, carrying the buffered word; stall_cycles_out=4 with PERF enabled, 0 without.
- redirect_in with redirect_pc_in=32'h2002 while a request is outstanding -> set_nop_out pulses; DRAIN discards the next response; next request address is 32'h2000; flush_count_out=1.
- redirect_in in the same cycle as op_done -> response not delivered, valid_out stays 0, set_nop_out=1, next request at the target.
- alu_op_done_in=0 when op_done arrives -> HOLD; when it rises, valid_out with the correct pc_out.
- fetch_pc=32'hFFFF_FFFC delivered -> next request address 32'h0000_0000.
